// File: rtl/latch_bank_reader.sv
// Sequences one-hot OE across a shared-bus latch bank and streams sampled words.
// Define LATCH_BANK_READER_PARITY_EN to add the BUS_P parity input and PERR flag.
module latch_bank_reader #(
  parameter int N_LATCH = 4,
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 2,
  localparam int IW = $clog2(N_LATCH),
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic               CK,
  input  logic               RN,
`ifdef LATCH_BANK_READER_PARITY_EN
  input  logic               BUS_P,
  output logic               PERR,
`endif
  input  logic               START,
  input  logic [WIDTH-1:0]   BUS_Q,
  output logic [N_LATCH-1:0] OE,
  output logic [WIDTH-1:0]   DOUT,
  output logic [IW-1:0]      DIDX,
  output logic               DVALID,
  input  logic               DREADY,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    ENABLE,
    HOLD
  } state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      cnt;
  logic               last_idx;
  logic               last_cnt;
  logic [N_LATCH-1:0] one_hot;

  assign last_idx = (idx == IW'(N_LATCH - 1));
  assign last_cnt = (cnt == CW'(SETTLE - 1));
  assign one_hot  = {{(N_LATCH-1){1'b0}}, 1'b1} << idx;

  always_ff @(posedge CK) begin
    if (!RN) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      OE     <= '0;
      DOUT   <= '0;
      DIDX   <= '0;
      DVALID <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
`ifdef LATCH_BANK_READER_PARITY_EN
      PERR   <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state <= TURN;
            idx   <= '0;
            BUSY  <= 1'b1;
          end
        end
        // one dead cycle so two latches never drive the bus together
        TURN: begin
          state <= ENABLE;
          cnt   <= '0;
          OE    <= one_hot;
        end
        ENABLE: begin
          cnt <= cnt + 1'b1;
          if (last_cnt) begin
            DOUT   <= BUS_Q;
            DIDX   <= idx;
            DVALID <= 1'b1;
            OE     <= '0;
            state  <= HOLD;
`ifdef LATCH_BANK_READER_PARITY_EN
            PERR   <= ^BUS_Q ^ BUS_P;
`endif
          end
        end
        HOLD: begin
          if (DVALID && DREADY) begin
            DVALID <= 1'b0;
`ifdef LATCH_BANK_READER_PARITY_EN
            PERR   <= 1'b0;
`endif
            if (last_idx) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= TURN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_reader.sv
// Directed bench for latch_bank_reader: reset, scan order, backpressure,
// START filtering, mid-scan reset and (when enabled) parity.
module tb_latch_bank_reader;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       START = 1'b0;
  logic [7:0] BUS_Q;
  logic [3:0] OE;
  logic [7:0] DOUT;
  logic [1:0] DIDX;
  logic       DVALID;
  logic       DREADY = 1'b1;
  logic       BUSY;
  logic       DONE;
`ifdef LATCH_BANK_READER_PARITY_EN
  logic       BUS_P = 1'b0;
  logic       PERR;
`endif

  int   n_run  = 0;
  int   n_fail = 0;
  bit   use_force = 1'b0;
  logic [7:0] force_val = 8'h00;
  logic [3:0] prev_oe = 4'b0;
  int   words;
  int   dones;

  latch_bank_reader #(
    .N_LATCH(4),
    .WIDTH  (8),
    .SETTLE (2)
  ) dut (
    .CK    (CK),
    .RN    (RN),
`ifdef LATCH_BANK_READER_PARITY_EN
    .BUS_P (BUS_P),
    .PERR  (PERR),
`endif
    .START (START),
    .BUS_Q (BUS_Q),
    .OE    (OE),
    .DOUT  (DOUT),
    .DIDX  (DIDX),
    .DVALID(DVALID),
    .DREADY(DREADY),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CK = ~CK;

  // latch i drives A0+i only while enabled
  always_comb begin
    BUS_Q = 'x;
    for (int i = 0; i < 4; i++)
      if (OE[i]) BUS_Q = 8'hA0 + 8'(i);
    if (use_force) BUS_Q = force_val;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // runs until DONE (bounded), counting words and DONE pulses
  task automatic collect(input bit pulse_at2, output int w, output int d);
    w = 0;
    d = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (DVALID) begin
        w++;
        chk("word_data", {24'b0, DOUT}, 32'hA0 + {30'b0, DIDX});
      end
      START = (pulse_at2 && OE == 4'b0100);
      if (DONE) begin
        d++;
        break;
      end
    end
    START = 1'b0;
  endtask

  always @(negedge CK) begin
    chk("oe_onehot", {31'b0, $onehot0(OE)}, 32'd1);
    if (prev_oe != 4'b0 && OE != 4'b0)
      chk("oe_bbm", {28'b0, OE}, {28'b0, prev_oe});
    prev_oe <= OE;
  end

  initial begin
    // reset with START held
    RN = 1'b0;
    START = 1'b1;
    repeat (3) step();
    chk("rst_oe", {28'b0, OE}, 32'd0);
    chk("rst_dvalid", {31'b0, DVALID}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_done", {31'b0, DONE}, 32'd0);
    chk("rst_dout", {24'b0, DOUT}, 32'd0);
    RN = 1'b1;
    START = 1'b0;
    step();
    step();
    chk("idle_busy", {31'b0, BUSY}, 32'd0);
    chk("idle_oe", {28'b0, OE}, 32'd0);

    // basic scan, cycle-exact
    DREADY = 1'b1;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("scan_busy", {31'b0, BUSY}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("scan_turn_oe", {28'b0, OE}, 32'd0);
      step();
      chk("scan_en1_oe", {28'b0, OE}, 32'd1 << i);
      step();
      chk("scan_en2_oe", {28'b0, OE}, 32'd1 << i);
      step();
      chk("scan_hold_oe", {28'b0, OE}, 32'd0);
      chk("scan_dvalid", {31'b0, DVALID}, 32'd1);
      chk("scan_dout", {24'b0, DOUT}, 32'hA0 + i);
      chk("scan_didx", {30'b0, DIDX}, i);
      chk("scan_nodone", {31'b0, DONE}, 32'd0);
      step();
    end
    chk("scan_done16", {31'b0, DONE}, 32'd1);
    chk("scan_idle_busy", {31'b0, BUSY}, 32'd0);
    chk("scan_idle_dv", {31'b0, DVALID}, 32'd0);
    step();
    chk("scan_done_pulse", {31'b0, DONE}, 32'd0);

    // backpressure in the first HOLD
    DREADY = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_dvalid", {31'b0, DVALID}, 32'd1);
      chk("bp_dout", {24'b0, DOUT}, 32'hA0);
      chk("bp_didx", {30'b0, DIDX}, 32'd0);
      chk("bp_oe", {28'b0, OE}, 32'd0);
      step();
    end
    DREADY = 1'b1;
    step();
    chk("bp_turn_dv", {31'b0, DVALID}, 32'd0);
    chk("bp_turn_oe", {28'b0, OE}, 32'd0);
    chk("bp_turn_busy", {31'b0, BUSY}, 32'd1);
    step();
    chk("bp_next_oe", {28'b0, OE}, 32'd2);
    collect(1'b0, words, dones);
    chk("bp_words", words, 32'd3);
    chk("bp_dones", dones, 32'd1);

    // START during the scan is ignored; START with DONE restarts
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    collect(1'b1, words, dones);
    chk("sds_words", words, 32'd4);
    chk("sds_dones", dones, 32'd1);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("restart_busy", {31'b0, BUSY}, 32'd1);
    chk("restart_turn", {28'b0, OE}, 32'd0);
    step();
    chk("restart_oe0", {28'b0, OE}, 32'd1);
    collect(1'b0, words, dones);
    chk("restart_words", words, 32'd4);
    chk("restart_dones", dones, 32'd1);

    // reset during ENABLE of idx 1
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (5) step();
    chk("mid_oe1", {28'b0, OE}, 32'd2);
    RN = 1'b0;
    step();
    chk("mid_rst_oe", {28'b0, OE}, 32'd0);
    chk("mid_rst_dv", {31'b0, DVALID}, 32'd0);
    chk("mid_rst_busy", {31'b0, BUSY}, 32'd0);
    chk("mid_rst_done", {31'b0, DONE}, 32'd0);
    RN = 1'b1;
    step();
    chk("mid_post_done", {31'b0, DONE}, 32'd0);
    chk("mid_post_busy", {31'b0, BUSY}, 32'd0);
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    chk("mid_rescan_oe", {28'b0, OE}, 32'd1);
    collect(1'b0, words, dones);
    chk("mid_words", words, 32'd4);

`ifdef LATCH_BANK_READER_PARITY_EN
    // parity: 03 even, 07 odd
    step();
    use_force = 1'b1;
    force_val = 8'h03;
    BUS_P = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (3) step();
    chk("par_dv0", {31'b0, DVALID}, 32'd1);
    chk("par_perr0", {31'b0, PERR}, 32'd0);
    force_val = 8'h07;
    repeat (4) step();
    chk("par_dv1", {31'b0, DVALID}, 32'd1);
    chk("par_perr1", {31'b0, PERR}, 32'd1);
    step();
    chk("par_clear", {31'b0, PERR}, 32'd0);
    use_force = 1'b0;
    repeat (12) step();
    chk("par_idle", {31'b0, BUSY}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
